// File: rtl/step_input_conditioner_if.sv
// Signals between raw board switches and the FSM step controls.
// The master drives the raw inputs and the slave returns the conditioned step controls.
interface step_input_conditioner_if;
  logic       step_raw;
  logic [1:0] code_raw;
  logic       enable;
  logic [1:0] a;
  logic [7:0] step_count;
  logic       held;

  modport master (output step_raw, code_raw, input enable, a, step_count, held);
  modport slave  (input step_raw, code_raw, output enable, a, step_count, held);
endinterface

// File: rtl/step_input_conditioner.sv
// Debounced single-step pulse generator with a held input code for the board FSM labs.
// Defining AUTO_REPEAT_EN adds periodic repeat pulses while the button stays held.
module step_input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input logic                      clock,
  input logic                      reset,
  step_input_conditioner_if.slave  io
);
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;

  logic [1:0]    step_sync_q;
  logic [1:0]    code_sync1_q, code_s_q;
  state_e        state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          enable_q, enable_d;
  logic [1:0]    a_q, a_d;
  logic [7:0]    count_q, count_d;
  logic          held_q, held_d;
  logic          pulse;
  logic          step_s;

  assign step_s = step_sync_q[1];

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rcnt_q, rcnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    enable_d = 1'b0;
    a_d      = a_q;
    count_d  = count_q;
    pulse    = 1'b0;
`ifdef AUTO_REPEAT_EN
    rcnt_d   = '0;
`endif
    case (state_q)
      IDLE: if (step_s) state_d = PRESS_WAIT;
      PRESS_WAIT: begin
        if (!step_s)             state_d = IDLE;
        else if (cnt_q == DLAST) begin
          state_d = HELD;
          pulse   = 1'b1;
        end else                 cnt_d = cnt_q + 1'b1;
      end
      HELD: begin
        if (!step_s) state_d = RELEASE_WAIT;
`ifdef AUTO_REPEAT_EN
        // Repeat only while the button stays down; release wins over a due repeat.
        else if (rcnt_q == RLAST) pulse = 1'b1;
        else rcnt_d = rcnt_q + 1'b1;
`endif
      end
      RELEASE_WAIT: begin
        if (step_s)              state_d = HELD;
        else if (cnt_q == DLAST) state_d = IDLE;
        else                     cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
    if (pulse) begin
      enable_d = 1'b1;
      a_d      = code_s_q;
      count_d  = count_q + 8'd1;
    end
    held_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      step_sync_q  <= '0;
      code_sync1_q <= '0;
      code_s_q     <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      enable_q     <= 1'b0;
      a_q          <= 2'b00;
      count_q      <= 8'd0;
      held_q       <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rcnt_q       <= '0;
`endif
    end else begin
      step_sync_q  <= {step_sync_q[0], io.step_raw};
      code_sync1_q <= io.code_raw;
      code_s_q     <= code_sync1_q;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      enable_q     <= enable_d;
      a_q          <= a_d;
      count_q      <= count_d;
      held_q       <= held_d;
`ifdef AUTO_REPEAT_EN
      rcnt_q       <= rcnt_d;
`endif
    end
  end

  assign io.enable     = enable_q;
  assign io.a          = a_q;
  assign io.step_count = count_q;
  assign io.held       = held_q;
endmodule
